data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/dmem_lane_unit.sv | 51 +++++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder: FSM state
// encoding, internal operation codes and the strobe decoder.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_SB   = 4'd1,
    OP_SH   = 4'd2,
    OP_SW   = 4'd3,
    OP_LB   = 4'd4,
    OP_LH   = 4'd5,
    OP_LW   = 4'd6,
    OP_LBU  = 4'd7,
    OP_LHU  = 4'd8
  } op_e;

  // Strobe order {lhu, lbu, lw, lh, lb, sw, sh, sb}; anything not one-hot is OP_NONE.
  function automatic op_e decode_op(input logic [7:0] strb);
    case (strb)
      8'b0000_0001: decode_op = OP_SB;
      8'b0000_0010: decode_op = OP_SH;
      8'b0000_0100: decode_op = OP_SW;
      8'b0000_1000: decode_op = OP_LB;
      8'b0001_0000: decode_op = OP_LH;
      8'b0010_0000: decode_op = OP_LW;
      8'b0100_0000: decode_op = OP_LBU;
      8'b1000_0000: decode_op = OP_LHU;
      default:      decode_op = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a core (master) and the data memory responder (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse with no back-pressure.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              sb, sh, sw, lb, lh, lw, lbu, lhu;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              resp_valid;
  logic [DATA_W-1:0] read_data;
  logic              resp_err;

  modport master (
    output req_valid, sb, sh, sw, lb, lh, lw, lbu, lhu, address, write_data,
    input  req_ready, resp_valid, read_data, resp_err
  );

  modport slave (
    input  req_valid, sb, sh, sw, lb, lh, lw, lbu, lhu, address, write_data,
    output req_ready, resp_valid, read_data, resp_err
  );

endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: little-endian store merge into the old word
// and load extract with sign/zero extension. Also flags misaligned accesses.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  op_e               op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] new_word,
  output logic [DATA_W-1:0] load_data,
  output logic              is_store,
  output logic              misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = old_word[{addr_lo, 3'b000} +: 8];
  assign half_v = old_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    new_word  = old_word;
    load_data = '0;
    is_store  = 1'b0;
    case (op)
      OP_SB: begin
        is_store = 1'b1;
        new_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      OP_SH: begin
        is_store = 1'b1;
        new_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      OP_SW: begin
        is_store = 1'b1;
        new_word = wdata;
      end
      OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      OP_LH:   load_data = {{16{half_v[15]}}, half_v};
      OP_LW:   load_data = old_word;
      OP_LBU:  load_data = {24'd0, byte_v};
      OP_LHU:  load_data = {16'd0, half_v};
      default: ;
    endcase
  end

  assign misaligned = ((op == OP_SH || op == OP_LH || op == OP_LHU) && addr_lo[0])
                   || ((op == OP_SW || op == OP_LW) && (addr_lo != 2'b00));

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: IDLE -> WAIT (WAIT_STATES cycles) -> RESP.
// Define DMEM_MISALIGN_ERR_EN to turn misaligned accesses into errored no-ops.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam logic [1:0] RESP = ST_RESP;
  localparam logic [WAIT_W-1:0] WS = WAIT_W'(WAIT_STATES);

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  op_e               op_q;
  logic [IDX_W+1:0]  addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  op_e               live_op;
  logic              enter_resp;
  op_e               acc_op;
  logic [IDX_W+1:0]  acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] new_word, load_data;
  logic              is_store, misaligned, access_ok, err_next;

  assign live_op = decode_op({bus.lhu, bus.lbu, bus.lw, bus.lh, bus.lb, bus.sw, bus.sh, bus.sb});

  // With no wait states the access happens on the accept edge, so it must use the live request.
  always_comb begin
    if (WAIT_STATES == 0) begin
      enter_resp = (state == IDLE) && bus.req_valid;
      acc_op     = live_op;
      acc_addr   = bus.address[IDX_W+1:0];
      acc_wdata  = bus.write_data;
    end else begin
      enter_resp = (state == WAIT) && (wait_cnt == WAIT_W'(1));
      acc_op     = op_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
  end

  dmem_lane_unit u_lane (
    .op         (acc_op),
    .addr_lo    (acc_addr[1:0]),
    .old_word   (mem[acc_addr[IDX_W+1:2]]),
    .wdata      (acc_wdata),
    .new_word   (new_word),
    .load_data  (load_data),
    .is_store   (is_store),
    .misaligned (misaligned)
  );

`ifdef DMEM_MISALIGN_ERR_EN
  assign access_ok = (acc_op != OP_NONE) && !misaligned;
  assign err_next  = !access_ok;
`else
  assign access_ok = (acc_op != OP_NONE);
  assign err_next  = 1'b0;
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[ADDR_W-1:IDX_W+2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      op_q     <= OP_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (enter_resp) begin
        rdata_q <= access_ok ? load_data : '0;
        err_q   <= err_next;
      end
      case (state)
        IDLE: if (bus.req_valid) begin
          op_q     <= live_op;
          addr_q   <= bus.address[IDX_W+1:0];
          wdata_q  <= bus.write_data;
          wait_cnt <= WS;
          state    <= (WAIT_STATES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - WAIT_W'(1);
          if (wait_cnt == WAIT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; the reset gate only stops a zero-wait access during reset.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && is_store && access_ok)
      mem[acc_addr[IDX_W+1:2]] <= new_word;
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.read_data  = rdata_q;
  assign bus.resp_err   = err_q;
  assign dbg_state      = state;

endmodule
